data_memory_responder: RTL and testbench

Responder end of the core's data-memory interface: accepts the word address, store data and read/write strobes driven from the ALU result, register bank and main controller, and services them against an internal word-organised RAM. It inserts a configurable number of wait states, signals completion with a one-cycle `ready` pulse, and holds read data until the next completed access. It sits between the datapath wiring and the memory array and models a multicycle data memory for the core.

---
 rtl/data_memory_responder.sv | 142 ++++++++++++++
 tb/tb_data_memory_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Multicycle data-memory responder: word RAM behind an IDLE/WAIT/RESPOND handshake.
// Optional access statistics (read_count/write_count) are built when DATA_MEMORY_STATS_EN is defined.
module data_memory_responder #(
    parameter int data_bits    = 32,
    parameter int address_bits = 30,
    parameter int depth_words  = 1024,
    parameter int wait_states  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [address_bits-1:0] read_address,
    input  logic [data_bits-1:0]    input_data,
    input  logic                    write_enable,
    input  logic                    read_enable,
    output logic [data_bits-1:0]    output_data,
    output logic                    ready,
    output logic                    busy,
    output logic                    out_of_range
`ifdef DATA_MEMORY_STATS_EN
    ,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    localparam int         IDX_W     = (depth_words > 1) ? $clog2(depth_words) : 1;
    localparam logic [3:0] WAIT_INIT = (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [address_bits-1:0] addr_q, addr_d;
    logic [data_bits-1:0]    wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic                    re_q, re_d;
    logic [data_bits-1:0]    rdata_q, rdata_d;
    logic                    oor_q, oor_d;
    logic                    enter_resp;
    logic                    in_range_d;
    logic [IDX_W-1:0]        idx_d;

    logic [data_bits-1:0]    mem [depth_words];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rdata_q <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            rdata_q <= rdata_d;
            oor_q   <= oor_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        re_d    = re_q;
        unique case (state_q)
            IDLE: begin
                if (write_enable || read_enable) begin
                    addr_d  = read_address;
                    wdata_d = input_data;
                    we_d    = write_enable;
                    re_d    = read_enable;
                    if (wait_states == 0) begin
                        state_d = RESPOND;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESPOND;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The _d copies of the captured access are used so a zero-wait access
    // (IDLE straight to RESPOND) sees its own address and data.
    assign in_range_d = (64'(addr_d) < 64'(depth_words));
    assign idx_d      = addr_d[IDX_W-1:0];

    always_comb begin
        enter_resp = (state_d == RESPOND) && (state_q != RESPOND);
        rdata_d    = rdata_q;
        oor_d      = 1'b0;
        if (enter_resp) begin
            rdata_d = in_range_d ? mem[idx_d] : '0;
            oor_d   = !in_range_d;
        end
    end

    // Read-before-write: rdata_d samples the old word on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && we_d && in_range_d) begin
            mem[idx_d] <= wdata_d;
        end
    end

    assign output_data  = rdata_q;
    assign ready        = (state_q == RESPOND);
    assign busy         = (state_q != IDLE);
    assign out_of_range = oor_q;

`ifdef DATA_MEMORY_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (enter_resp) begin
            if (re_d && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (we_d && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: table vectors, hand sequences for multi-cycle
// corners, and randomized accesses checked against an associative-array memory model.
module tb_data_memory_responder;

    localparam int WS    = 2;
    localparam int DEPTH = 1024;
    localparam int AW    = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic          we, re;
    logic [31:0]   dout;
    logic          rdy, bsy, oor;

    logic [AW-1:0] addr0;
    logic [31:0]   din0;
    logic          we0, re0;
    logic [31:0]   dout0;
    logic          rdy0, bsy0, oor0;

`ifdef DATA_MEMORY_STATS_EN
    logic [31:0] rc, wc, rc0, wc0;
`endif

    always #5 clk = ~clk;

    data_memory_responder #(.data_bits(32), .address_bits(AW), .depth_words(DEPTH), .wait_states(WS)) u_dut (
        .clk(clk), .rst(rst), .read_address(addr), .input_data(din),
        .write_enable(we), .read_enable(re), .output_data(dout),
        .ready(rdy), .busy(bsy), .out_of_range(oor)
`ifdef DATA_MEMORY_STATS_EN
        , .read_count(rc), .write_count(wc)
`endif
    );

    data_memory_responder #(.data_bits(32), .address_bits(AW), .depth_words(16), .wait_states(0)) u_dut0 (
        .clk(clk), .rst(rst), .read_address(addr0), .input_data(din0),
        .write_enable(we0), .read_enable(re0), .output_data(dout0),
        .ready(rdy0), .busy(bsy0), .out_of_range(oor0)
`ifdef DATA_MEMORY_STATS_EN
        , .read_count(rc0), .write_count(wc0)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [int];
    int m_reads = 0, m_writes = 0, m_reads0 = 0, m_writes0 = 0;

    typedef struct {
        int          a;
        logic [31:0] d;
        logic        w;
        logic        r;
        logic [31:0] exp_d;
        logic        chk_d;
        logic        exp_oor;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic do_access(input int a, input logic [31:0] d, input logic w, input logic r,
                             input logic [31:0] exp_d, input logic chk_d, input logic exp_oor);
        int k;
        @(negedge clk);
        addr = a[AW-1:0]; din = d; we = w; re = r;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        chk("busy_after_accept", 32'(bsy), 32'd1);
        k = 1;
        while (!rdy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ready_latency", k, WS + 1);
        chk("busy_in_respond", 32'(bsy), 32'd1);
        if (chk_d) chk("output_data", dout, exp_d);
        chk("out_of_range", 32'(oor), 32'(exp_oor));
        @(negedge clk);
        chk("ready_single_pulse", 32'(rdy), 32'd0);
        chk("busy_back_idle", 32'(bsy), 32'd0);
        chk("oor_outside_respond", 32'(oor), 32'd0);
        if (r) m_reads++;
        if (w) m_writes++;
        if (w && a < DEPTH) model[a] = d;
    endtask

    task automatic do_access0(input int a, input logic [31:0] d, input logic w, input logic r,
                              input logic [31:0] exp_d, input logic chk_d, input logic exp_oor);
        @(negedge clk);
        addr0 = a[AW-1:0]; din0 = d; we0 = w; re0 = r;
        @(negedge clk);
        we0 = 1'b0; re0 = 1'b0;
        chk("ws0_ready_next_cycle", 32'(rdy0), 32'd1);
        chk("ws0_busy", 32'(bsy0), 32'd1);
        chk("ws0_oor", 32'(oor0), 32'(exp_oor));
        if (chk_d) chk("ws0_output_data", dout0, exp_d);
        @(negedge clk);
        chk("ws0_ready_drop", 32'(rdy0), 32'd0);
        chk("ws0_busy_drop", 32'(bsy0), 32'd0);
        if (r) m_reads0++;
        if (w) m_writes0++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses, pos, mask, exp_mask, a, sel;
        logic [31:0] dsav, d, exp_d;
        logic w, r, inr;

        tbl[0]  = '{5,    32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{5,    32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[2]  = '{5,    32'h12345678, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[3]  = '{5,    32'h0,        1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0};
        tbl[4]  = '{0,    32'h11111111, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[5]  = '{1023, 32'h22222222, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[6]  = '{1024, 32'h33333333, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1};
        tbl[7]  = '{1024, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 1'b1};
        tbl[8]  = '{1024, 32'h44444444, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1};
        tbl[9]  = '{0,    32'h0,        1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0};
        tbl[10] = '{1023, 32'h0,        1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0};
        tbl[11] = '{7,    32'hA5A5A5A5, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[12] = '{0,    32'h55555555, 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0};
        tbl[13] = '{0,    32'h0,        1'b0, 1'b1, 32'h55555555, 1'b1, 1'b0};

        rst = 1'b1; addr = '0; din = '0; we = 1'b0; re = 1'b0;
        addr0 = '0; din0 = '0; we0 = 1'b0; re0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_output_data", dout, 32'h0);
        chk("reset_ready", 32'(rdy), 32'd0);
        chk("reset_busy", 32'(bsy), 32'd0);
        chk("reset_oor", 32'(oor), 32'd0);
`ifdef DATA_MEMORY_STATS_EN
        chk("reset_read_count", rc, 32'd0);
        chk("reset_write_count", wc, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            do_access(tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].r, tbl[i].exp_d, tbl[i].chk_d, tbl[i].exp_oor);

        // strobes wiggled while the read of word 0 is in flight must be ignored
        @(negedge clk);
        addr = '0; re = 1'b1; we = 1'b0;
        pulses = 0; pos = 0; dsav = '0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (rdy) begin pulses++; pos = j; dsav = dout; end
            case (j)
                1: begin re = 1'b0; we = 1'b1; addr = 30'd1023; din = 32'hFFFF0000; end
                2: begin we = 1'b0; re = 1'b1; addr = 30'd2; end
                3: begin we = 1'b0; re = 1'b0; end
                default: ;
            endcase
        end
        m_reads++;
        chk("wait_strobe_pulses", pulses, 1);
        chk("wait_strobe_ready_pos", pos, WS + 1);
        chk("wait_strobe_data", dsav, 32'h55555555);
        do_access(1023, 32'h0, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0);

        // held read strobe: a completion every WS+2 cycles
        @(negedge clk);
        addr = 30'd5; re = 1'b1;
        mask = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (rdy) mask |= (1 << j);
            if (j == 12) re = 1'b0;
        end
        exp_mask = 0;
        for (int k = 0; WS + 1 + k * (WS + 2) <= 12; k++) begin
            exp_mask |= (1 << (WS + 1 + k * (WS + 2)));
            m_reads++;
        end
        chk("held_read_ready_mask", mask, exp_mask);
        chk("held_read_data", dout, 32'h12345678);
        repeat (WS + 2) @(negedge clk);
        chk("held_read_idle", 32'(bsy), 32'd0);

        // reset during the first WAIT cycle of a write aborts it
        @(negedge clk);
        addr = 30'd7; din = 32'h0BADF00D; we = 1'b1;
        @(negedge clk);
        we = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("midreset_output_data", dout, 32'h0);
        chk("midreset_ready", 32'(rdy), 32'd0);
        chk("midreset_busy", 32'(bsy), 32'd0);
        chk("midreset_oor", 32'(oor), 32'd0);
        rst = 1'b0;
        m_reads = 0; m_writes = 0; m_reads0 = 0; m_writes0 = 0;
        do_access(7, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);

        // 3 reads (one above), 2 writes, 1 read+write
        do_access(5, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0);
        do_access(0, 32'h0, 1'b0, 1'b1, 32'h55555555, 1'b1, 1'b0);
        do_access(8, 32'h00000008, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        do_access(9, 32'h00000009, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        do_access(8, 32'h80808080, 1'b1, 1'b1, 32'h00000008, 1'b1, 1'b0);
`ifdef DATA_MEMORY_STATS_EN
        chk("stats_read_count", rc, 32'd4);
        chk("stats_write_count", wc, 32'd3);
`endif

        // zero-wait instance
        do_access0(3, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        do_access0(3, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        do_access0(16, 32'h77777777, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
        do_access0(3, 32'h01020304, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        do_access0(3, 32'h0, 1'b0, 1'b1, 32'h01020304, 1'b1, 1'b0);
`ifdef DATA_MEMORY_STATS_EN
        chk("ws0_read_count", rc0, 32'(m_reads0));
        chk("ws0_write_count", wc0, 32'(m_writes0));
`endif

        // randomized accesses against the memory model
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = $urandom_range(DEPTH, DEPTH + 40);
            else if (sel == 1) a = 32'h3FFF_FFFF;
            else               a = $urandom_range(0, 47);
            d   = $urandom;
            case ($urandom_range(1, 3))
                1:       begin w = 1'b1; r = 1'b0; end
                2:       begin w = 1'b0; r = 1'b1; end
                default: begin w = 1'b1; r = 1'b1; end
            endcase
            inr   = (a < DEPTH);
            exp_d = !inr ? 32'h0 : (model.exists(a) ? model[a] : 32'h0);
            do_access(a, d, w, r, exp_d, !inr || model.exists(a), !inr);
        end
`ifdef DATA_MEMORY_STATS_EN
        chk("final_read_count", rc, 32'(m_reads));
        chk("final_write_count", wc, 32'(m_writes));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
